// File: rtl/cmp_sort_if.sv
// cmp_sort_if: load/drain streams and control handshake for cmp_sort_ctrl.
interface cmp_sort_if #(parameter int W = 8);
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         start;
    logic         s_mode;
    logic         busy;
    logic         done;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready;

    modport master (
        output in_valid, in_data, start, s_mode, out_ready,
        input  in_ready, busy, done, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, start, s_mode, out_ready,
        output in_ready, busy, done, out_valid, out_data
    );
endinterface

// File: rtl/cmp_sort_ctrl.sv
// cmp_sort_ctrl: in-place ascending bubble sort of an N-entry buffer through one
// shared signed/unsigned comparator, with valid/ready load and drain streams.
module cmp_sort_ctrl #(
    parameter int N = 4,
    parameter int W = 8
) (
    input logic       clk,
    input logic       rst_n,
    cmp_sort_if.slave bus
);
    localparam int JW = $clog2(N);
    localparam int FW = $clog2(N + 1);
    localparam logic [FW-1:0] FULL    = FW'(N);
    localparam logic [JW-1:0] LAST_J  = JW'(N - 2);
    localparam logic [JW-1:0] LAST_RD = JW'(N - 1);

    typedef enum logic [1:0] {IDLE, SORT, DRAIN} state_t;

    state_t        r_state;
    logic [FW-1:0] r_fill;
    logic [JW-1:0] r_j;
    logic [JW-1:0] r_pass;
    logic [JW-1:0] r_rd;
    logic          r_swapped;
    logic          r_mode;
    logic          r_done;
    logic [W-1:0]  r_mem [N];

    logic [JW-1:0] w_j1;
    logic [W-1:0]  w_a;
    logic [W-1:0]  w_b;
    logic          w_gt;
    logic          w_sw;
    logic          w_in_ready;

    always_comb begin
        w_j1       = r_j + 1'b1;
        w_a        = r_mem[r_j];
        w_b        = r_mem[w_j1];
        w_gt       = r_mode ? ($signed(w_a) > $signed(w_b)) : (w_a > w_b);
        w_sw       = r_swapped | w_gt;
        w_in_ready = (r_state == IDLE) && (r_fill < FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_fill    <= '0;
            r_j       <= '0;
            r_pass    <= '0;
            r_rd      <= '0;
            r_swapped <= 1'b0;
            r_mode    <= 1'b0;
            r_done    <= 1'b0;
            for (int i = 0; i < N; i++) r_mem[i] <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.in_valid && w_in_ready) begin
                        r_mem[r_fill[JW-1:0]] <= bus.in_data;
                        r_fill                <= r_fill + 1'b1;
                    end
                    if (bus.start && r_fill == FULL) begin
                        r_mode    <= bus.s_mode;
                        r_j       <= '0;
                        r_pass    <= '0;
                        r_swapped <= 1'b0;
                        r_state   <= SORT;
                    end
                end
                SORT: begin
                    if (w_gt) begin
                        r_mem[r_j]  <= w_b;
                        r_mem[w_j1] <= w_a;
                    end
                    r_swapped <= w_sw;
                    if (r_j != LAST_J) begin
                        r_j <= r_j + 1'b1;
                    end else if (!w_sw || r_pass == LAST_J) begin
                        r_rd    <= '0;
                        r_state <= DRAIN;
                    end else begin
                        r_pass    <= r_pass + 1'b1;
                        r_j       <= '0;
                        r_swapped <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (bus.out_ready) begin
                        r_rd <= r_rd + 1'b1;
                        if (r_rd == LAST_RD) begin
                            r_fill  <= '0;
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.busy      = r_state != IDLE;
    assign bus.done      = r_done;
    assign bus.out_valid = r_state == DRAIN;
    assign bus.out_data  = (r_state == DRAIN) ? r_mem[r_rd] : '0;
endmodule

// File: tb/tb_cmp_sort_ctrl.sv
// tb_cmp_sort_ctrl: directed scenarios for cmp_sort_ctrl with hand-computed results.
module tb_cmp_sort_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_pass = 0;
    int n_total = 0;

    cmp_sort_if #(.W(8)) bus ();

    cmp_sort_ctrl #(.N(4), .W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic load(input logic [7:0] v);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic load4(input logic [31:0] v);
        for (int i = 3; i >= 0; i--) load(v[i*8 +: 8]);
    endtask

    // Returns at the negedge where out_valid first rises; cyc = SORT cycles seen.
    task automatic run_sort(input logic mode, output int cyc);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.s_mode = mode;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        while (bus.out_valid !== 1'b1 && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic drain(input string name, input logic [31:0] exp, input int gap);
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < gap; g++) begin
                n_total++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== exp[(3-i)*8 +: 8] || bus.done !== 1'b0)
                    $display("FAIL %s hold[%0d]: valid=%b data=%h done=%b, want valid=1 data=%h done=0",
                             name, i, bus.out_valid, bus.out_data, bus.done, exp[(3-i)*8 +: 8]);
                else n_pass++;
                @(negedge clk);
            end
            n_total++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== exp[(3-i)*8 +: 8] || bus.done !== 1'b0)
                $display("FAIL %s out[%0d]: valid=%b data=%h done=%b, want valid=1 data=%h done=0",
                         name, i, bus.out_valid, bus.out_data, bus.done, exp[(3-i)*8 +: 8]);
            else n_pass++;
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
        end
        n_total++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.in_ready !== 1'b1)
            $display("FAIL %s end: done=%b busy=%b valid=%b data=%h in_ready=%b, want 1 0 0 00 1",
                     name, bus.done, bus.busy, bus.out_valid, bus.out_data, bus.in_ready);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (bus.done !== 1'b0) $display("FAIL %s done_pulse: done=%b, want 0", name, bus.done);
        else n_pass++;
    endtask

    task automatic test_reset();
        int cyc;
        n_total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.in_ready !== 1'b1)
            $display("FAIL reset_state: busy=%b done=%b valid=%b data=%h in_ready=%b, want 0 0 0 00 1",
                     bus.busy, bus.done, bus.out_valid, bus.out_data, bus.in_ready);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        load4(32'h11223344);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL reset_mid_sort: busy=%b valid=%b in_ready=%b, want 0 0 1",
                     bus.busy, bus.out_valid, bus.in_ready);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(8'h40 - i);
            n_total++;
            if (bus.in_ready !== 1'b1) $display("FAIL reload[%0d]: in_ready=%b, want 1", i, bus.in_ready);
            else n_pass++;
        end
        @(negedge clk);
        n_total++;
        if (bus.in_ready !== 1'b0) $display("FAIL fifth_load: in_ready=%b, want 0", bus.in_ready);
        else n_pass++;
        bus.in_valid = 1'b0;
        run_sort(1'b0, cyc);
        n_total++;
        if (cyc !== 9) $display("FAIL reload_sort_cycles: got %0d, want 9", cyc);
        else n_pass++;
        drain("reload", 32'h3D3E3F40, 0);
    endtask

    task automatic test_unsigned_worst();
        int cyc;
        load4(32'h04030201);
        run_sort(1'b0, cyc);
        n_total++;
        if (cyc !== 9) $display("FAIL worst_cycles: got %0d, want 9", cyc);
        else n_pass++;
        drain("worst", 32'h01020304, 0);
    endtask

    task automatic test_signed_vs_unsigned();
        int cyc;
        load4(32'hC0401080);
        run_sort(1'b1, cyc);
        n_total++;
        if (cyc !== 9) $display("FAIL signed_cycles: got %0d, want 9", cyc);
        else n_pass++;
        drain("signed", 32'h80C01040, 0);
        load4(32'hC0401080);
        run_sort(1'b0, cyc);
        n_total++;
        if (cyc !== 9) $display("FAIL unsigned_cycles: got %0d, want 9", cyc);
        else n_pass++;
        drain("unsigned", 32'h104080C0, 0);
    endtask

    task automatic test_early_exit();
        int cyc;
        load4(32'h05050707);
        run_sort(1'b0, cyc);
        n_total++;
        if (cyc !== 3) $display("FAIL early_exit_cycles: got %0d, want 3", cyc);
        else n_pass++;
        drain("ties", 32'h05050707, 0);
    endtask

    task automatic test_handshake_gaps();
        int cyc;
        load4(32'h0A010B02);
        run_sort(1'b0, cyc);
        n_total++;
        if (cyc !== 9) $display("FAIL gaps_cycles: got %0d, want 9", cyc);
        else n_pass++;
        drain("gaps", 32'h01020A0B, 3);
    endtask

    task automatic test_illegal();
        int cyc;
        load(8'h30);
        load(8'h20);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.s_mode = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        n_total++;
        if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL early_start: busy=%b in_ready=%b, want 0 1", bus.busy, bus.in_ready);
        else n_pass++;
        load(8'h90);
        load(8'h10);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.s_mode = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.s_mode   = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        n_total++;
        if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0)
            $display("FAIL sort_entry: busy=%b in_ready=%b, want 1 0", bus.busy, bus.in_ready);
        else n_pass++;
        cyc = 0;
        while (bus.out_valid !== 1'b1 && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        n_total++;
        if (cyc !== 9) $display("FAIL illegal_cycles: got %0d, want 9", cyc);
        else n_pass++;
        drain("mode_hold", 32'h90102030, 0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.start     = 1'b0;
        bus.s_mode    = 1'b0;
        bus.out_ready = 1'b0;
        #2;
        test_reset();
        test_unsigned_worst();
        test_signed_vs_unsigned();
        test_early_exit();
        test_handshake_gaps();
        test_illegal();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/cmp_sort_ctrl.md
Name: cmp_sort_ctrl

Overview:
Sequencing controller that owns one shared W-bit magnitude comparator with a signed/unsigned mode select, and uses it to sort an N-entry buffer in place, ascending.
- Entries are loaded through a valid/ready stream.
- The sort is a bubble sort: one compare-and-conditional-swap per cycle, with early exit.
- Sorted entries drain out through a second valid/ready stream.
- The block is the scheduler that reuses the datapath comparator in the arithmetic and sorting subsystem.

Parameters:
- N, 4, number of buffer entries (N >= 2)
- W, 8, entry width in bits

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  load data valid
- in_data  input  W  load data
- in_ready  output  1  buffer can accept a load
- start  input  1  request sort (single-cycle pulse or level)
- s_mode  input  1  compare mode, sampled at start: 1 = two's-complement signed, 0 = unsigned
- busy  output  1  high in SORT and DRAIN
- done  output  1  one-cycle pulse after the last drained entry
- out_valid  output  1  drain data valid
- out_data  output  W  drain data
- out_ready  input  1  downstream accepts out_data

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE; fill, j, pass and rd counters = 0; swapped = 0; mode_q = 0.
  - All buffer entries = 0.
  - Outputs: busy = 0, done = 0, out_valid = 0, out_data = 0, in_ready = 1.
  - Reset mid-SORT or mid-DRAIN discards all data.
- Compare function: gt(a, b).
  - mode_q = 1: a > b as signed W-bit values. mode_q = 0: a > b as unsigned.
  - The comparison is strict, so equal entries never swap (stable sort).
- IDLE:
  - in_ready = (fill < N).
  - On in_valid & in_ready: mem[fill] <= in_data, fill++.
  - in_valid while fill == N is ignored.
  - start is accepted only when fill == N. On acceptance: mode_q <= s_mode, j = 0, pass = 0, swapped = 0, go to SORT.
  - start while fill < N is ignored; no state change.
- SORT (one pair per cycle; in_ready = 0, out_valid = 0, busy = 1):
  - If gt(mem[j], mem[j+1]), swap the two entries and set swapped.
  - If j < N-2: j++.
  - If j == N-2 (end of pass), let sw = swapped OR the swap made this cycle:
    - If sw == 0 or pass == N-2: go to DRAIN, rd = 0.
    - Otherwise: pass++, j = 0, swapped = 0.
  - SORT length is (passes executed) × (N-1) cycles: minimum N-1, maximum (N-1)².
  - start and in_valid are ignored in SORT.
- DRAIN (busy = 1):
  - out_valid = 1, out_data = mem[rd] (combinational from rd).
  - On out_ready: rd++.
  - On the handshake with rd == N-1: go to IDLE, fill = 0, and register done = 1 for exactly the next cycle (the first IDLE cycle).
  - out_valid is held with stable data while out_ready = 0; there is no timeout.
- out_data = 0 whenever out_valid = 0.
- The buffer is not cleared on the return to IDLE; the next load overwrites it.
- Latency from accepted start to first out_valid = SORT cycles + 1.

Test Plan:
- Reset mid-SORT: load 4 entries, start, assert rst_n = 0 during the 2nd SORT cycle → immediately busy = 0, out_valid = 0, in_ready = 1; after release, 4 new loads are accepted, a 5th is refused (in_ready = 0).
- Unsigned, worst-case order: load 0x04, 0x03, 0x02, 0x01; start with s_mode = 0 → busy for 9 SORT cycles; out_valid on cycle 10; drain with out_ready = 1 yields 0x01, 0x02, 0x03, 0x04; done pulses once.
- Signed vs unsigned on the same data: load 0xC0, 0x40, 0x10, 0x80.
  - s_mode = 1 → drain 0x80, 0xC0, 0x10, 0x40 after 9 SORT cycles.
  - Repeat with s_mode = 0 → drain 0x10, 0x40, 0x80, 0xC0 after 9 SORT cycles.
- Early exit and ties: load 0x05, 0x05, 0x07, 0x07 → exactly 3 SORT cycles, output order unchanged.
- Handshake gaps: during DRAIN, hold out_ready = 0 for 3 cycles between entries → out_data stays stable, rd does not advance, no entry is lost or duplicated, done is asserted only after the 4th handshake.
- Illegal requests: start with fill = 2 → ignored, state stays IDLE; in_valid pulses during SORT → ignored, buffer contents unaffected; changing s_mode during SORT → result uses the mode sampled at start.
